// File: rtl/adpll_lock_ctrl_pkg.sv
// Shared types for the ADPLL lock controller: FSM state encoding,
// phase-detector direction and the decision decode helper.
package adpll_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      COARSE = 3'd1,
      FINE   = 3'd2,
      LOCKED = 3'd3
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   // Up alone means the DCO is slow, Dn alone means fast; both or neither
   // carry no usable information.
   function automatic dir_t decode_dir(input logic i_up, input logic i_dn);
      dir_t v_dir;
      case ({i_up, i_dn})
         2'b10:   v_dir = DIR_UP;
         2'b01:   v_dir = DIR_DN;
         default: v_dir = DIR_NONE;
      endcase
      return v_dir;
   endfunction

endpackage

// File: rtl/adpll_settle_ctr.sv
// Loadable down-counter. o_ready is high once the count has run out,
// i.e. the DCO has had the requested number of cycles to settle.
module adpll_settle_ctr
   import adpll_pkg::*;
#(
   parameter int WIDTH = 3
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_ready
);

   logic [WIDTH-1:0] r_cnt;

   // Reload on every word update, otherwise count down and stop at zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != {WIDTH{1'b0}}) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_ready = (r_cnt == {WIDTH{1'b0}});

endmodule

// File: rtl/adpll_lock_ctrl.sv
// ADPLL frequency acquisition and lock controller. Binary-searches the
// coarse DCO word, then tracks with single fine steps, declares lock after
// enough direction reversals and drops lock on a sustained one-sided error.
module adpll_lock_ctrl
   import adpll_pkg::*;
#(
   parameter int CW_COARSE  = 6,
   parameter int CW_FINE    = 8,
   parameter int LOCK_CNT   = 16,
   parameter int SETTLE     = 4,
   parameter int UNLOCK_THR = 4
)(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 En,
   input  logic                 Pfd_Valid,
   input  logic                 Pfd_Up,
   input  logic                 Pfd_Dn,
   output logic [CW_COARSE-1:0] Coarse_Word,
   output logic [CW_FINE-1:0]   Fine_Word,
   output logic                 Dco_Load,
   output logic                 Locked,
   output logic [2:0]           State
);

   localparam int IW = (CW_COARSE > 1) ? $clog2(CW_COARSE) : 1;
   localparam int RW = $clog2(LOCK_CNT + 1);
   localparam int UW = $clog2(UNLOCK_THR + 1);
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   localparam logic [CW_COARSE-1:0] C_MID  = {1'b1, {(CW_COARSE-1){1'b0}}};
   localparam logic [CW_COARSE-1:0] C_MAX  = {CW_COARSE{1'b1}};
   localparam logic [CW_COARSE-1:0] C_ZERO = {CW_COARSE{1'b0}};
   localparam logic [CW_FINE-1:0]   F_MID  = {1'b1, {(CW_FINE-1){1'b0}}};
   localparam logic [CW_FINE-1:0]   F_MAX  = {CW_FINE{1'b1}};
   localparam logic [CW_FINE-1:0]   F_ZERO = {CW_FINE{1'b0}};
   localparam logic [IW-1:0]        IDX_TOP    = IW'(CW_COARSE - 1);
   localparam logic [RW-1:0]        REV_LOCK   = RW'(LOCK_CNT);
   localparam logic [UW-1:0]        RUN_THR    = UW'(UNLOCK_THR);
   localparam logic [SW-1:0]        SETTLE_VAL = SW'(SETTLE);

   state_t               r_state,    w_state;
   logic [CW_COARSE-1:0] r_coarse,   w_coarse;
   logic [CW_FINE-1:0]   r_fine,     w_fine;
   logic [IW-1:0]        r_idx,      w_idx;
   logic [RW-1:0]        r_rev_cnt,  w_rev_cnt;
   logic [UW-1:0]        r_run_cnt,  w_run_cnt;
   dir_t                 r_prev_dir, w_prev_dir;
   logic                 r_locked,   w_locked;
   logic                 r_dco_load;

   dir_t                 w_dir;
   logic                 w_ready;
   logic                 w_strobe;
   logic                 w_decide;
   logic                 w_update;
   logic                 w_carry;
   logic                 w_at_edge;
   logic                 w_coarse_lim;
   logic                 w_reversal;
   logic                 w_same;
   logic [UW-1:0]        w_run_inc;

   adpll_settle_ctr #(
      .WIDTH (SW)
   ) u_settle (
      .i_clk      (Clk),
      .i_rst      (Reset),
      .i_load     (w_update),
      .i_load_val (SETTLE_VAL),
      .o_ready    (w_ready)
   );

   assign w_dir        = decode_dir(Pfd_Up, Pfd_Dn);
   assign w_strobe     = Pfd_Valid & w_ready;
   assign w_decide     = w_strobe & (w_dir != DIR_NONE);
   assign w_at_edge    = (w_dir == DIR_UP) ? (r_fine == F_MAX) : (r_fine == F_ZERO);
   assign w_coarse_lim = (w_dir == DIR_UP) ? (r_coarse == C_MAX) : (r_coarse == C_ZERO);
   assign w_reversal   = (r_prev_dir != DIR_NONE) && (w_dir != r_prev_dir);
   assign w_same       = (w_dir == r_prev_dir);
   assign w_run_inc    = (r_run_cnt < RUN_THR) ? (r_run_cnt + UW'(1)) : r_run_cnt;

   // Next-state, word datapath and bookkeeping for every FSM state.
   always_comb begin
      w_state    = r_state;
      w_coarse   = r_coarse;
      w_fine     = r_fine;
      w_idx      = r_idx;
      w_rev_cnt  = r_rev_cnt;
      w_run_cnt  = r_run_cnt;
      w_prev_dir = r_prev_dir;
      w_locked   = r_locked;
      w_update   = 1'b0;
      w_carry    = 1'b0;

      if ((r_state != IDLE) && !En) begin
         // Dropping enable parks the controller with the words frozen.
         w_state  = IDLE;
         w_locked = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (En) begin
                  w_state    = COARSE;
                  w_idx      = IDX_TOP;
                  w_coarse   = C_MID;
                  w_fine     = F_MID;
                  w_rev_cnt  = {RW{1'b0}};
                  w_run_cnt  = {UW{1'b0}};
                  w_prev_dir = DIR_NONE;
                  w_locked   = 1'b0;
                  w_update   = 1'b1;
               end else begin
                  w_state = IDLE;
               end
            end

            COARSE: begin
               if (w_decide) begin
                  // Keep the trial bit on Up, drop it on Dn, then try the next one.
                  if (w_dir == DIR_DN) begin
                     w_coarse[r_idx] = 1'b0;
                  end else begin
                     w_coarse[r_idx] = 1'b1;
                  end
                  if (r_idx != {IW{1'b0}}) begin
                     w_coarse[r_idx - IW'(1)] = 1'b1;
                     w_idx = r_idx - IW'(1);
                  end else begin
                     w_state    = FINE;
                     w_fine     = F_MID;
                     w_prev_dir = DIR_NONE;
                     w_rev_cnt  = {RW{1'b0}};
                  end
                  w_update = 1'b1;
               end else begin
                  w_state = COARSE;
               end
            end

            FINE, LOCKED: begin
               if (w_decide) begin
                  w_prev_dir = w_dir;
                  if (!w_at_edge) begin
                     w_fine   = (w_dir == DIR_UP) ? (r_fine + CW_FINE'(1)) : (r_fine - CW_FINE'(1));
                     w_update = 1'b1;
                  end else if (!w_coarse_lim) begin
                     // Fine range exhausted: move one coarse step and recentre.
                     w_coarse = (w_dir == DIR_UP) ? (r_coarse + CW_COARSE'(1))
                                                  : (r_coarse - CW_COARSE'(1));
                     w_fine   = F_MID;
                     w_update = 1'b1;
                     w_carry  = 1'b1;
                  end else begin
                     w_update = 1'b0;
                  end

                  if (r_state == FINE) begin
                     if (w_carry) begin
                        w_rev_cnt = {RW{1'b0}};
                     end else if (w_reversal && (r_rev_cnt < REV_LOCK)) begin
                        w_rev_cnt = r_rev_cnt + RW'(1);
                        if (r_rev_cnt == (REV_LOCK - RW'(1))) begin
                           w_state   = LOCKED;
                           w_locked  = 1'b1;
                           w_run_cnt = {UW{1'b0}};
                        end else begin
                           w_state = FINE;
                        end
                     end else begin
                        w_rev_cnt = r_rev_cnt;
                     end
                  end else begin
                     w_run_cnt = w_same ? w_run_inc : UW'(1);
                     if (w_carry || (w_run_cnt >= RUN_THR)) begin
                        w_state   = FINE;
                        w_locked  = 1'b0;
                        w_rev_cnt = {RW{1'b0}};
                        w_run_cnt = {UW{1'b0}};
                     end else begin
                        w_state = LOCKED;
                     end
                  end
               end else if (w_strobe) begin
                  // Ambiguous comparison: breaks a one-sided run, nothing more.
                  w_run_cnt = {UW{1'b0}};
               end else begin
                  w_run_cnt = r_run_cnt;
               end
            end

            default: begin
               w_state  = IDLE;
               w_locked = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers; Dco_Load flags the first cycle of a new word.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_coarse   <= C_MID;
         r_fine     <= F_MID;
         r_idx      <= {IW{1'b0}};
         r_rev_cnt  <= {RW{1'b0}};
         r_run_cnt  <= {UW{1'b0}};
         r_prev_dir <= DIR_NONE;
         r_locked   <= 1'b0;
         r_dco_load <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_coarse   <= w_coarse;
         r_fine     <= w_fine;
         r_idx      <= w_idx;
         r_rev_cnt  <= w_rev_cnt;
         r_run_cnt  <= w_run_cnt;
         r_prev_dir <= w_prev_dir;
         r_locked   <= w_locked;
         r_dco_load <= w_update;
      end
   end

   assign Coarse_Word = r_coarse;
   assign Fine_Word   = r_fine;
   assign Dco_Load    = r_dco_load;
   assign Locked      = r_locked;
   assign State       = r_state;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Bench for adpll_lock_ctrl: directed walk through acquisition, lock,
// unlock and boundaries, then random decisions, all against a reference model
// with a load-event scoreboard.
module tb_adpll_lock_ctrl;

   localparam int CWC = 6;
   localparam int CWF = 8;
   localparam int LCK = 4;
   localparam int STL = 2;
   localparam int UTH = 3;
   localparam int CMID = 1 << (CWC - 1);
   localparam int CMAX = (1 << CWC) - 1;
   localparam int FMID = 1 << (CWF - 1);
   localparam int FMAX = (1 << CWF) - 1;
   localparam int S_IDLE = 0, S_COARSE = 1, S_FINE = 2, S_LOCKED = 3;

   logic           Clk = 1'b0;
   logic           Reset = 1'b1;
   logic           En = 1'b0;
   logic           Pfd_Valid = 1'b0;
   logic           Pfd_Up = 1'b0;
   logic           Pfd_Dn = 1'b0;
   logic [CWC-1:0] Coarse_Word;
   logic [CWF-1:0] Fine_Word;
   logic           Dco_Load;
   logic           Locked;
   logic [2:0]     State;

   adpll_lock_ctrl #(
      .CW_COARSE  (CWC),
      .CW_FINE    (CWF),
      .LOCK_CNT   (LCK),
      .SETTLE     (STL),
      .UNLOCK_THR (UTH)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .En          (En),
      .Pfd_Valid   (Pfd_Valid),
      .Pfd_Up      (Pfd_Up),
      .Pfd_Dn      (Pfd_Dn),
      .Coarse_Word (Coarse_Word),
      .Fine_Word   (Fine_Word),
      .Dco_Load    (Dco_Load),
      .Locked      (Locked),
      .State       (State)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int cyc;
      int coarse;
      int fine;
      int st;
      int lk;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;

   // Reference model state: plain integers, words as numbers, directions +1/-1.
   int m_state, m_coarse, m_fine, m_locked, m_i, m_rev, m_run, m_prev, m_wait;

   int s_c, s_f, s_s, s_l, s_ld;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_coarse = CMID; m_fine = FMID; m_locked = 0;
      m_i = 0; m_rev = 0; m_run = 0; m_prev = 0; m_wait = 0;
      sb.delete();
   endtask

   task automatic model_step();
      int d, nf, nc;
      bit load, carry, rev_flag, same, dec_ok;
      load = 0;
      carry = 0;
      dec_ok = Pfd_Valid && (m_wait == 0) && (Pfd_Up != Pfd_Dn);
      if (m_state != S_IDLE && !En) begin
         m_state = S_IDLE;
         m_locked = 0;
      end else if (m_state == S_IDLE) begin
         if (En) begin
            m_state = S_COARSE; m_coarse = CMID; m_fine = FMID; m_i = CWC - 1;
            m_rev = 0; m_run = 0; m_prev = 0; load = 1;
         end
      end else if (dec_ok) begin
         d = Pfd_Up ? 1 : -1;
         if (m_state == S_COARSE) begin
            // Binary search as arithmetic: move by half of the current trial weight.
            if (m_i > 0) begin
               m_coarse += d * (1 << (m_i - 1));
               m_i--;
            end else begin
               if (d < 0) m_coarse -= 1;
               m_state = S_FINE; m_fine = FMID; m_prev = 0; m_rev = 0;
            end
            load = 1;
         end else begin
            rev_flag = (m_prev != 0) && (d != m_prev);
            same = (d == m_prev);
            m_prev = d;
            nf = m_fine + d;
            if (nf >= 0 && nf <= FMAX) begin
               m_fine = nf; load = 1;
            end else begin
               nc = m_coarse + d;
               if (nc >= 0 && nc <= CMAX) begin
                  m_coarse = nc; m_fine = FMID; load = 1; carry = 1;
               end
            end
            if (m_state == S_FINE) begin
               if (carry) m_rev = 0;
               else if (rev_flag) begin
                  m_rev++;
                  if (m_rev >= LCK) begin
                     m_state = S_LOCKED; m_locked = 1; m_run = 0;
                  end
               end
            end else begin
               m_run = same ? ((m_run < UTH) ? m_run + 1 : m_run) : 1;
               if (carry || m_run >= UTH) begin
                  m_state = S_FINE; m_locked = 0; m_rev = 0; m_run = 0;
               end
            end
         end
      end else if (Pfd_Valid && m_wait == 0 && (m_state == S_FINE || m_state == S_LOCKED)) begin
         m_run = 0;
      end
      if (load) m_wait = STL;
      else if (m_wait > 0) m_wait--;
      if (load) sb.push_back('{cyc, m_coarse, m_fine, m_state, m_locked});
   endtask

   // Advance the model on the same edge the DUT samples its inputs.
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         model_reset();
      end else begin
         cyc++;
         model_step();
      end
   end

   // Monitor: match load pulses against the scoreboard, track status every cycle.
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("sb_missed_load", 0, 1);
         end
         if (Dco_Load) begin
            if (sb.size() == 0) begin
               chk("sb_spurious_load", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sb_load_cycle", cyc, e.cyc);
               chk("sb_load_coarse", int'(Coarse_Word), e.coarse);
               chk("sb_load_fine", int'(Fine_Word), e.fine);
               chk("sb_load_state", int'(State), e.st);
               chk("sb_load_locked", int'(Locked), e.lk);
            end
         end
         chk("mon_state", int'(State), m_state);
         chk("mon_locked", int'(Locked), m_locked);
         chk("mon_coarse", int'(Coarse_Word), m_coarse);
         chk("mon_fine", int'(Fine_Word), m_fine);
      end
   end

   task automatic step(input logic v, input logic u, input logic d);
      Pfd_Valid = v; Pfd_Up = u; Pfd_Dn = d;
      @(posedge Clk);
      #1;
      Pfd_Valid = 1'b0; Pfd_Up = 1'b0; Pfd_Dn = 1'b0;
   endtask

   // One decision, snapshot of the outputs it produced, then the settle window
   // filled with opposite-direction strobes that must be ignored.
   task automatic dec(input logic u, input logic d, input logic junk);
      step(1'b1, u, d);
      s_c = int'(Coarse_Word); s_f = int'(Fine_Word); s_s = int'(State);
      s_l = int'(Locked); s_ld = int'(Dco_Load);
      repeat (STL) step(junk, d, u);
   endtask

   int exp_c[6] = '{48, 40, 44, 46, 45, 44};
   bit dir_c[6] = '{1, 0, 1, 1, 0, 0};
   int exp_f[5] = '{129, 128, 129, 128, 129};
   int exp_up3[3] = '{48, 56, 60};
   int exp_up6[6] = '{48, 56, 60, 62, 63, 63};

   initial begin
      int x;
      logic v, u, d;
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      chk("rst_state", int'(State), S_IDLE);
      chk("rst_coarse", int'(Coarse_Word), 32);
      chk("rst_fine", int'(Fine_Word), 128);
      chk("rst_load", int'(Dco_Load), 0);
      chk("rst_locked", int'(Locked), 0);

      // Enable: start the coarse search from the midpoint.
      En = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("en_state", int'(State), S_COARSE);
      chk("en_coarse", int'(Coarse_Word), 32);
      chk("en_fine", int'(Fine_Word), 128);
      chk("en_load", int'(Dco_Load), 1);
      step(1'b1, 1'b1, 1'b0);
      chk("en_load_once", int'(Dco_Load), 0);
      chk("en_settle_ignored", int'(Coarse_Word), 32);
      step(1'b1, 1'b0, 1'b1);

      for (int k = 0; k < 6; k++) begin
         dec(dir_c[k], ~dir_c[k], 1'b1);
         chk("coarse_word", s_c, exp_c[k]);
         chk("coarse_load", s_ld, 1);
      end
      chk("coarse_done_state", s_s, S_FINE);
      chk("coarse_done_fine", s_f, 128);

      for (int k = 0; k < 5; k++) begin
         dec(k % 2 == 0, k % 2 == 1, 1'b1);
         chk("fine_word", s_f, exp_f[k]);
         chk("fine_state", s_s, (k == 4) ? S_LOCKED : S_FINE);
         chk("fine_locked", s_l, (k == 4) ? 1 : 0);
      end

      for (int k = 0; k < 3; k++) begin
         dec(1'b0, 1'b1, 1'b1);
         chk("unlock_fine", s_f, 128 - k);
         chk("unlock_state", s_s, (k == 2) ? S_FINE : S_LOCKED);
         chk("unlock_locked", s_l, (k == 2) ? 0 : 1);
      end

      // Relock, then show an ambiguous strobe breaking the one-sided run.
      dec(1'b1, 1'b0, 1'b1);
      dec(1'b0, 1'b1, 1'b1);
      dec(1'b1, 1'b0, 1'b1);
      dec(1'b0, 1'b1, 1'b1);
      chk("relock_state", s_s, S_LOCKED);
      dec(1'b0, 1'b1, 1'b1);
      dec(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("both_no_load", int'(Dco_Load), 0);
      chk("both_fine", int'(Fine_Word), 124);
      dec(1'b0, 1'b1, 1'b1);
      chk("run_cleared_state", s_s, S_LOCKED);
      dec(1'b0, 1'b1, 1'b1);
      chk("run_cleared_state2", s_s, S_LOCKED);
      dec(1'b0, 1'b1, 1'b1);
      chk("run_unlock_state", s_s, S_FINE);
      chk("run_unlock_fine", s_f, 121);

      // Walk the fine word to its top and carry into the coarse word.
      repeat (134) dec(1'b1, 1'b0, 1'b1);
      chk("top_fine", s_f, 255);
      chk("top_coarse", s_c, 44);
      dec(1'b1, 1'b0, 1'b1);
      chk("carry_coarse", s_c, 45);
      chk("carry_fine", s_f, 128);
      chk("carry_load", s_ld, 1);

      En = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      chk("dis_state", int'(State), S_IDLE);
      chk("dis_coarse", int'(Coarse_Word), 45);
      chk("dis_load", int'(Dco_Load), 0);
      En = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("reen_coarse", int'(Coarse_Word), 32);
      chk("reen_fine", int'(Fine_Word), 128);
      repeat (STL) step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         dec(1'b1, 1'b0, 1'b1);
         chk("midc_coarse", s_c, exp_up3[k]);
      end
      En = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      chk("midc_dis_state", int'(State), S_IDLE);
      chk("midc_dis_coarse", int'(Coarse_Word), 60);
      chk("midc_dis_fine", int'(Fine_Word), 128);
      chk("midc_dis_load", int'(Dco_Load), 0);
      En = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("reen2_coarse", int'(Coarse_Word), 32);
      repeat (STL) step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         dec(1'b1, 1'b0, 1'b1);
         chk("allup_coarse", s_c, exp_up6[k]);
      end
      repeat (127) dec(1'b1, 1'b0, 1'b1);
      chk("max_fine", s_f, 255);
      chk("max_coarse", s_c, 63);
      step(1'b1, 1'b1, 1'b0);
      chk("hold_load", int'(Dco_Load), 0);
      chk("hold_coarse", int'(Coarse_Word), 63);
      chk("hold_fine", int'(Fine_Word), 255);
      step(1'b0, 1'b0, 1'b0);
      chk("hold_load_late", int'(Dco_Load), 0);

      // Lock at the ceiling, then hit it with an asynchronous reset.
      dec(1'b0, 1'b1, 1'b1);
      dec(1'b1, 1'b0, 1'b1);
      dec(1'b0, 1'b1, 1'b1);
      dec(1'b1, 1'b0, 1'b1);
      chk("ceil_lock_state", s_s, S_LOCKED);
      #2 Reset = 1'b1;
      #1;
      chk("arst_state", int'(State), S_IDLE);
      chk("arst_coarse", int'(Coarse_Word), 32);
      chk("arst_fine", int'(Fine_Word), 128);
      chk("arst_load", int'(Dco_Load), 0);
      chk("arst_locked", int'(Locked), 0);
      @(negedge Clk);
      #1 Reset = 1'b0;

      // Random decisions, checked by the monitor against the model.
      for (int n = 0; n < 3000; n++) begin
         En = ($urandom_range(0, 149) != 0);
         x = $urandom_range(0, 11);
         v = (x < 10);
         u = (x < 5) || (x == 9) || (x == 11);
         d = ((x >= 5) && (x < 10));
         step(v, u, d);
      end

      @(negedge Clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
